transmitting: RTL and testbench



---
 rtl/transmitting_pkg.sv | 26 ++
 rtl/transmitting_bit_timer.sv | 37 +++
 rtl/transmitting.sv | 134 +++++++++++++
 tb/tb_transmitting.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/transmitting_pkg.sv
// Shared frame constants and state encoding for the serial transmitter and receiver.
package transmitting_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 16;
  localparam int unsigned DEFAULT_DATA_BITS    = 7;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // start + data + parity + stop
  localparam int unsigned FRAME_BITS = DEFAULT_DATA_BITS + 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/transmitting_bit_timer.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle.
module transmitting_bit_timer
  import transmitting_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick_c
);

  localparam int unsigned DIV_W = cnt_width(CLKS_PER_BIT);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLKS_PER_BIT - 1);

  logic [DIV_W-1:0] count_q;

  // Terminal count: last cycle of the current bit period.
  assign tick_c = enable && (count_q == LAST);

  // Divider register; wraps to zero on the terminal count so it never leaves its range.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      if (tick_c) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/transmitting.sv
// Serial transmitter: start bit, LSB-first data, parity, stop bit; each bit held one bit period.
module transmitting
  import transmitting_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 data_out,
  output logic                 busy,
  output logic                 char_sent
);

  localparam int unsigned CNT_W = cnt_width(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 parity_q, parity_d;
  logic                 data_out_d;
  logic                 busy_d;
  logic                 char_sent_d;
  logic [DATA_BITS-1:0] shift_next;
  logic                 tick_c;

  transmitting_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == ST_IDLE),
    .enable (state_q != ST_IDLE),
    .tick_c (tick_c)
  );

  // Data register after dropping the bit just sent.
  assign shift_next = shift_q >> 1;

  // State and output registers; line idles high and returns high immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      data_out  <= STOP_BIT;
      busy      <= 1'b0;
      char_sent <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      data_out  <= data_out_d;
      busy      <= busy_d;
      char_sent <= char_sent_d;
    end
  end

  // Next-state logic; outputs are computed one cycle ahead so the line comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    parity_d    = parity_q;
    data_out_d  = data_out;
    busy_d      = busy;
    char_sent_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        data_out_d = STOP_BIT;
        busy_d     = 1'b0;
        if (load) begin
          shift_d    = data_in;
          parity_d   = (^data_in) ^ 1'(PARITY_ODD);
          bit_cnt_d  = '0;
          state_d    = ST_START;
          data_out_d = START_BIT;
          busy_d     = 1'b1;
        end
      end

      ST_START: begin
        if (tick_c) begin
          state_d    = ST_DATA;
          bit_cnt_d  = '0;
          data_out_d = shift_q[0];
        end
      end

      ST_DATA: begin
        if (tick_c) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d    = ST_PARITY;
            data_out_d = parity_q;
          end else begin
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
            shift_d    = shift_next;
            data_out_d = shift_next[0];
          end
        end
      end

      ST_PARITY: begin
        if (tick_c) begin
          state_d    = ST_STOP;
          data_out_d = STOP_BIT;
        end
      end

      ST_STOP: begin
        if (tick_c) begin
          state_d     = ST_IDLE;
          data_out_d  = STOP_BIT;
          busy_d      = 1'b0;
          char_sent_d = 1'b1;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        data_out_d = STOP_BIT;
        busy_d     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_transmitting.sv
// Directed and randomized frame checks of the transmitter against an idealised line model.
module tb_transmitting;
  import transmitting_pkg::*;

  localparam int unsigned CPB          = 16;
  localparam int unsigned DB           = 7;
  localparam logic        PODD         = 1'b0;
  localparam int          FRAME_CYCLES = FRAME_BITS * CPB;

  logic          clk = 1'b0;
  logic          reset;
  logic          load;
  logic [DB-1:0] data_in;
  logic          data_out;
  logic          busy;
  logic          char_sent;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  transmitting #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .PARITY_ODD   (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .data_in   (data_in),
    .data_out  (data_out),
    .busy      (busy),
    .char_sent (char_sent)
  );

  // Ideal frame, index 0 goes on the line first.
  function automatic logic [FRAME_BITS-1:0] frame_of(input logic [DB-1:0] d);
    int ones = 0;
    logic p;
    for (int i = 0; i < DB; i++) ones += int'(d[i]);
    p = ((ones % 2) == 1) ^ PODD;
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_line", 32'(data_out), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_sent", 32'(char_sent), 32'd0);
    end
  endtask

  // Present a character with load high ahead of the next rising edge.
  task automatic present(input logic [DB-1:0] d);
    @(negedge clk);
    load    = 1'b1;
    data_in = d;
  endtask

  // Follow one frame cycle by cycle; optionally hold load, inject a load mid-frame or stop early.
  task automatic run_frame(input logic [DB-1:0] d, input bit hold, input logic [DB-1:0] next_d,
                           input int inject_k, input int abort_k);
    logic [FRAME_BITS-1:0] f;
    f = frame_of(d);
    for (int k = 1; k <= FRAME_CYCLES + 1; k++) begin
      @(negedge clk);
      if (k <= FRAME_CYCLES) begin
        check("frame_line", 32'(data_out), 32'(f[(k-1)/CPB]));
        check("frame_busy", 32'(busy), 32'd1);
        check("frame_sent", 32'(char_sent), 32'd0);
      end else begin
        check("end_line", 32'(data_out), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_sent", 32'(char_sent), 32'd1);
      end
      if (k == abort_k) return;
      if (k == 1) begin
        if (!hold) load = 1'b0;
        data_in = DB'($urandom);
      end
      if (inject_k != 0 && k == inject_k) begin
        load    = 1'b1;
        data_in = 7'h12;
      end
      if (inject_k != 0 && k == inject_k + 1) begin
        load    = 1'b0;
        data_in = DB'($urandom);
      end
      if (hold && k == FRAME_CYCLES) data_in = next_d;
    end
  endtask

  initial begin
    logic [DB-1:0] d0, d1;

    reset   = 1'b1;
    load    = 1'b0;
    data_in = '0;
    #1;
    check("reset_line", 32'(data_out), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_sent", 32'(char_sent), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle_check(5);

    // Basic frame and parity corners.
    present(7'h4B); run_frame(7'h4B, 1'b0, '0, 0, 0); idle_check(10);
    present(7'h7F); run_frame(7'h7F, 1'b0, '0, 0, 0); idle_check(5);
    present(7'h00); run_frame(7'h00, 1'b0, '0, 0, 0); idle_check(5);

    // Load while busy is ignored and not queued.
    present(7'h4B); run_frame(7'h4B, 1'b0, '0, 50, 0); idle_check(200);

    // Load held high: back-to-back frames with a single idle cycle (the char_sent cycle).
    present(7'h4B); run_frame(7'h4B, 1'b1, 7'h35, 0, 0);
    run_frame(7'h35, 1'b0, '0, 0, 0); idle_check(10);

    // Asynchronous reset between edges in the middle of a frame.
    present(7'h4B); run_frame(7'h4B, 1'b0, '0, 0, 70);
    #2 reset = 1'b1;
    #1;
    check("midrst_line", 32'(data_out), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sent", 32'(char_sent), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle_check(20);
    present(7'h4B); run_frame(7'h4B, 1'b0, '0, 0, 0); idle_check(5);

    // Random characters, single and back-to-back.
    for (int i = 0; i < 6; i++) begin
      d0 = DB'($urandom);
      d1 = DB'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        present(d0); run_frame(d0, 1'b1, d1, 0, 0);
        run_frame(d1, 1'b0, '0, 0, 0);
      end else begin
        present(d0); run_frame(d0, 1'b0, '0, 0, 0);
      end
      idle_check(int'($urandom_range(8, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
